// File: rtl/inst_checker.sv
// inst_checker: scores a loadable table of (instruction count, expected output) checkpoints
// against CPU debug outputs. Optional macro INST_CHECKER_CONTINUE_ON_FAIL_EN keeps running past failures.
module inst_checker #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 58,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 30000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tbl_we,
  input  logic [IDX_W-1:0]     i_tbl_idx,
  input  logic [WORD_SIZE-1:0] i_tbl_num_inst,
  input  logic [WORD_SIZE-1:0] i_tbl_ans,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_num_inst,
  input  logic [WORD_SIZE-1:0] i_output_port,
  input  logic                 i_is_halted,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_done_cause,
  output logic                 o_all_pass,
  output logic [IDX_W:0]       o_pass_count,
  output logic [IDX_W:0]       o_fail_count,
  output logic [IDX_W:0]       o_noresult_count,
  output logic [IDX_W-1:0]     o_first_fail_idx,
  output logic [WORD_SIZE-1:0] o_first_fail_val,
  output logic [CNT_W-1:0]     o_cycle_count
);

  localparam int               DEPTH   = 1 << IDX_W;
  localparam logic [IDX_W:0]   NT      = (IDX_W+1)'(NUM_TEST);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_TEST-1);
  localparam logic [CNT_W-1:0] CYC_LIM = CNT_W'(MAX_CYCLES-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_n;

  // Table is deliberately left out of reset so a rerun needs no reload.
  logic [WORD_SIZE-1:0] r_exp [DEPTH];
  logic [WORD_SIZE-1:0] r_ans [DEPTH];

  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W:0]       r_pass, r_fail, r_nores;
  logic [IDX_W-1:0]     r_ff_idx;
  logic [WORD_SIZE-1:0] r_ff_val;
  logic [CNT_W-1:0]     r_cycle;
  logic [1:0]           r_cause;

  logic [WORD_SIZE-1:0] w_exp, w_ans;
  logic                 w_hit, w_skip, w_pass, w_fail, w_wrap, w_stop;
  logic [IDX_W:0]       w_pass_n, w_fail_n;
  logic [CNT_W-1:0]     w_cyc_n;
  logic [1:0]           w_cause;

  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_tbl_we && ({1'b0, i_tbl_idx} < NT)) begin
      r_exp[i_tbl_idx] <= i_tbl_num_inst;
      r_ans[i_tbl_idx] <= i_tbl_ans;
    end
  end

  assign w_exp    = r_exp[r_ptr];
  assign w_ans    = r_ans[r_ptr];
  assign w_hit    = (i_num_inst == w_exp);
  assign w_skip   = (i_num_inst > w_exp);
  assign w_fail   = w_hit && (i_output_port != w_ans);
  assign w_pass   = w_hit && !w_fail;
  assign w_wrap   = (w_hit || w_skip) && (r_ptr == LAST);
  assign w_cyc_n  = (&r_cycle) ? r_cycle : r_cycle + CNT_W'(1);
  assign w_pass_n = r_pass + (IDX_W+1)'(w_pass);
  assign w_fail_n = r_fail + (IDX_W+1)'(w_fail);

  always_comb begin
    w_state_n = r_state;
    w_stop    = 1'b0;
    w_cause   = 2'd0;
`ifdef INST_CHECKER_CONTINUE_ON_FAIL_EN
    if (i_is_halted) begin
      w_stop = 1'b1; w_cause = 2'd2;
    end else if (w_cyc_n == CYC_LIM) begin
      w_stop = 1'b1; w_cause = 2'd3;
    end else if (w_wrap) begin
      w_stop = 1'b1; w_cause = (w_fail_n != '0) ? 2'd1 : 2'd0;
    end
`else
    if (w_fail) begin
      w_stop = 1'b1; w_cause = 2'd1;
    end else if (i_is_halted) begin
      w_stop = 1'b1; w_cause = 2'd2;
    end else if (w_cyc_n == CYC_LIM) begin
      w_stop = 1'b1; w_cause = 2'd3;
    end else if (w_wrap) begin
      w_stop = 1'b1; w_cause = 2'd0;
    end
`endif
    case (r_state)
      S_IDLE:  if (i_start) w_state_n = S_RUN;
      S_RUN:   if (w_stop)  w_state_n = S_DONE;
      S_DONE:  if (i_start) w_state_n = S_RUN;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (i_start && r_state != S_RUN)) begin
      r_ptr    <= '0;
      r_pass   <= '0;
      r_fail   <= '0;
      r_nores  <= '0;
      r_ff_idx <= '0;
      r_ff_val <= '0;
      r_cycle  <= '0;
      r_cause  <= '0;
    end else if (r_state == S_RUN) begin
      r_cycle <= w_cyc_n;
      r_pass  <= w_pass_n;
      r_fail  <= w_fail_n;
      if (w_hit || w_skip) r_ptr <= w_wrap ? '0 : r_ptr + IDX_W'(1);
      if (w_skip) r_nores <= r_nores + (IDX_W+1)'(1);
      if (w_fail && r_fail == '0) begin
        r_ff_idx <= r_ptr;
        r_ff_val <= i_output_port;
      end
      // Final tally also absorbs entries left unresolved by halt or timeout.
      if (w_stop) begin
        r_cause <= w_cause;
        r_nores <= NT - w_pass_n - w_fail_n;
      end
    end
  end

  assign o_busy           = (r_state == S_RUN);
  assign o_done           = (r_state == S_DONE);
  assign o_done_cause     = r_cause;
  assign o_all_pass       = o_done && (r_pass == NT);
  assign o_pass_count     = r_pass;
  assign o_fail_count     = r_fail;
  assign o_noresult_count = r_nores;
  assign o_first_fail_idx = r_ff_idx;
  assign o_first_fail_val = r_ff_val;
  assign o_cycle_count    = r_cycle;

endmodule
